alarm_sequencer: RTL and testbench
==================================

ALARM_SEQUENCER -- requirements
Module: alarm_sequencer

Interface
REQ-001 Parameter EXIT_CYCLES, default 16, exit-delay length in clocks (legal 1..63).
REQ-002 Parameter ENTRY_CYCLES, default 8, entry-delay length in clocks (legal 1..63).
REQ-003 Parameter SIREN_CYCLES, default 32, alarm-active length in clocks (legal 1..63).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 arm_req  input  1  request to arm; sampled each cycle.
REQ-007 disarm  input  1  disarm command; sampled each cycle.
REQ-008 sensor  input  4  one bit per zone; 1 = zone tripped.
REQ-009 zone_en  input  4  per-zone enable; 0 = zone ignored.
REQ-010 state  output  3  current state encoding.
REQ-011 alarm  output  1  siren drive, registered.
REQ-012 armed  output  1  1 in ARMED, ENTRY_DELAY or ALARM.
REQ-013 zone_id  output  2  zone that caused the last trigger.
REQ-014 zone_valid  output  1  zone_id holds a latched trigger.
REQ-015 timer  output  6  current countdown value; 0 outside timed states.

Function
REQ-016 States SHALL be DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4; codes 5..7 SHALL go to DISARMED next cycle.
REQ-017 disarm=1 SHALL force DISARMED next cycle from any state; disarm has priority over every other input.
REQ-018 DISARMED with arm_req=1 and disarm=0 SHALL go to EXIT_DELAY next cycle, loading timer with EXIT_CYCLES-1.
REQ-019 arm_req SHALL be ignored in every state other than DISARMED.
REQ-020 In each timed state (EXIT_DELAY, ENTRY_DELAY, ALARM), timer SHALL decrement by 1 per cycle; the state SHALL exit on the cycle after timer==0. Each timed state therefore lasts exactly its parameter in cycles.
REQ-021 EXIT_DELAY SHALL ignore sensor and go to ARMED on expiry.
REQ-022 ARMED with (sensor & zone_en)!=0 SHALL go to ENTRY_DELAY next cycle, loading ENTRY_CYCLES-1, latching the granted zone into zone_id and setting zone_valid=1.
REQ-023 Simultaneous requests SHALL be granted round-robin: search starts at pointer ptr and wraps 3->0; after a grant, ptr = (grant+1) mod 4.
REQ-024 ENTRY_DELAY SHALL ignore new sensor activity, hold zone_id, and go to ALARM on expiry, loading SIREN_CYCLES-1.
REQ-025 alarm SHALL be 1 exactly in the cycles where state==ALARM; both SHALL update on the same edge.
REQ-026 ALARM expiry SHALL return to ARMED with alarm=0; zone_id and zone_valid are retained. A still-active sensor SHALL re-trigger on the next cycle.
REQ-027 A new trigger SHALL overwrite zone_id; zone_valid SHALL clear only on entry to DISARMED.
REQ-028 armed SHALL be combinational from state; all other outputs SHALL be registered.

Reset
REQ-029 rst_n=0 at a clock edge SHALL set state=DISARMED, alarm=0, timer=0, zone_id=0, zone_valid=0, ptr=0, regardless of the current state, including mid-ALARM.
REQ-030 Reset SHALL take priority over disarm and arm_req.

Structure
REQ-031 The state encodings, default parameter values and NZONES=4 SHALL live in a shared package, alarm_pkg.
REQ-032 Round-robin grant logic SHALL be a sub-module, rr_arbiter4 (req[3:0], ptr[1:0] -> gnt_valid, gnt_id[1:0]), with the ptr register kept in alarm_sequencer.

Verification
REQ-033 Defaults; arm_req pulse at cycle 0 -> EXIT_DELAY in cycles 1..16, ARMED at cycle 17, timer 15 at cycle 1 and 0 at cycle 16.
REQ-034 ARMED; sensor=4'b0100, zone_en=4'hF -> ENTRY_DELAY next cycle, zone_id=2, zone_valid=1; ALARM after 8 cycles; alarm=1 for exactly 32 cycles, then ARMED with alarm=0.
REQ-035 ARMED, ptr=0; sensor=4'b1010 twice, disarming and re-arming in between -> first grant zone_id=1, second grant zone_id=3.
REQ-036 zone_en=4'b1110, sensor=4'b0001 in ARMED -> no transition; state remains ARMED.
REQ-037 Mid-ALARM: disarm=1 -> DISARMED and alarm=0 next cycle, zone_valid=0. A repeat run with rst_n=0 mid-ALARM -> all outputs at reset values next cycle.
REQ-038 DISARMED with arm_req=1 and disarm=1 in the same cycle -> stays DISARMED; arm_req pulses during ARMED -> no state change.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer: state encodings,
// zone count, field widths and default timing parameters.
package alarm_pkg;

  localparam int NZONES  = 4;
  localparam int ZONE_W  = 2;
  localparam int TIMER_W = 6;
  localparam int STATE_W = 3;

  localparam int DEF_EXIT_CYCLES  = 16;
  localparam int DEF_ENTRY_CYCLES = 8;
  localparam int DEF_SIREN_CYCLES = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_e;

  // Round-robin pointer following a grant; wraps 3 -> 0 through the width.
  function automatic logic [ZONE_W-1:0] next_ptr(input logic [ZONE_W-1:0] gnt);
    return gnt + ZONE_W'(1);
  endfunction

endpackage

// File: rtl/alarm_sequencer_rr_arbiter4.sv
// Four-way round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping from zone 3 back to zone 0.
module rr_arbiter4
  import alarm_pkg::*;
(
  input  logic [NZONES-1:0] req,
  input  logic [ZONE_W-1:0] ptr,
  output logic              gnt_valid,
  output logic [ZONE_W-1:0] gnt_id
);

  logic [ZONE_W-1:0] cand [NZONES];

  // cand[k] is the zone examined k-th in the search order.
  for (genvar gi = 0; gi < NZONES; gi++) begin : g_cand
    assign cand[gi] = ptr + ZONE_W'(gi);
  end

  // Walk from lowest to highest priority so the earliest match wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ptr;
    for (int i = NZONES - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand[i];
      end
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// Intruder-alarm sequencer: exit delay, armed watch, entry delay and a
// timed siren, with round-robin attribution of the triggering zone.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int EXIT_CYCLES  = DEF_EXIT_CYCLES,
  parameter int ENTRY_CYCLES = DEF_ENTRY_CYCLES,
  parameter int SIREN_CYCLES = DEF_SIREN_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm_req,
  input  logic               disarm,
  input  logic [NZONES-1:0]  sensor,
  input  logic [NZONES-1:0]  zone_en,
  output logic [STATE_W-1:0] state,
  output logic               alarm,
  output logic               armed,
  output logic [ZONE_W-1:0]  zone_id,
  output logic               zone_valid,
  output logic [TIMER_W-1:0] timer
);

  localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               alarm_q, alarm_d;
  logic [ZONE_W-1:0]  zone_id_q, zone_id_d;
  logic               zone_valid_q, zone_valid_d;
  logic [ZONE_W-1:0]  ptr_q, ptr_d;

  logic               gnt_valid;
  logic [ZONE_W-1:0]  gnt_id;

  rr_arbiter4 u_arb (
    .req       (sensor & zone_en),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    zone_id_d    = zone_id_q;
    zone_valid_d = zone_valid_q;
    ptr_d        = ptr_q;

    case (state_q)
      ST_DISARMED: begin
        if (arm_req) begin
          state_d = ST_EXIT_DELAY;
          timer_d = EXIT_LOAD;
        end
      end
      ST_EXIT_DELAY: begin
        if (timer_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_ARMED: begin
        if (gnt_valid) begin
          state_d      = ST_ENTRY_DELAY;
          timer_d      = ENTRY_LOAD;
          zone_id_d    = gnt_id;
          zone_valid_d = 1'b1;
          ptr_d        = next_ptr(gnt_id);
        end
      end
      ST_ENTRY_DELAY: begin
        if (timer_q == '0) begin
          state_d = ST_ALARM;
          timer_d = SIREN_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_ALARM: begin
        // Return to watching; a sensor still tripped re-triggers next cycle.
        if (timer_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: begin
        state_d      = ST_DISARMED;
        timer_d      = '0;
        zone_valid_d = 1'b0;
      end
    endcase

    // Disarm overrides everything; the round-robin pointer survives it.
    if (disarm) begin
      state_d      = ST_DISARMED;
      timer_d      = '0;
      zone_id_d    = zone_id_q;
      zone_valid_d = 1'b0;
      ptr_d        = ptr_q;
    end

    alarm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_DISARMED;
      timer_q      <= '0;
      alarm_q      <= 1'b0;
      zone_id_q    <= '0;
      zone_valid_q <= 1'b0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      alarm_q      <= alarm_d;
      zone_id_q    <= zone_id_d;
      zone_valid_q <= zone_valid_d;
      ptr_q        <= ptr_d;
    end
  end

  assign state      = state_q;
  assign alarm      = alarm_q;
  assign timer      = timer_q;
  assign zone_id    = zone_id_q;
  assign zone_valid = zone_valid_q;
  assign armed      = (state_q == ST_ARMED) || (state_q == ST_ENTRY_DELAY) ||
                      (state_q == ST_ALARM);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with default timing parameters.
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm_req;
  logic       disarm;
  logic [3:0] sensor;
  logic [3:0] zone_en;
  logic [2:0] state;
  logic       alarm;
  logic       armed;
  logic [1:0] zone_id;
  logic       zone_valid;
  logic [5:0] timer;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alarm_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm_req    (arm_req),
    .disarm     (disarm),
    .sensor     (sensor),
    .zone_en    (zone_en),
    .state      (state),
    .alarm      (alarm),
    .armed      (armed),
    .zone_id    (zone_id),
    .zone_valid (zone_valid),
    .timer      (timer)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("[TB] %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".state"}, 32'(state), 0);
    check({tag, ".alarm"}, 32'(alarm), 0);
    check({tag, ".timer"}, 32'(timer), 0);
    check({tag, ".zone_id"}, 32'(zone_id), 0);
    check({tag, ".zone_valid"}, 32'(zone_valid), 0);
    check({tag, ".armed"}, 32'(armed), 0);
  endtask

  // Arm from DISARMED and run through the 16-cycle exit delay into ARMED.
  task automatic arm_fully();
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    step(16);
  endtask

  initial begin
    rst_n = 1'b0; arm_req = 1'b0; disarm = 1'b0; sensor = 4'h0; zone_en = 4'hF;
    step(2);
    check_reset_vals("reset");

    // Exit delay timing
    rst_n = 1'b1;
    arm_req = 1'b1;
    step();
    arm_req = 1'b0;
    check("exit.c1.state", 32'(state), 1);
    check("exit.c1.timer", 32'(timer), 15);
    check("exit.c1.armed", 32'(armed), 0);
    step(15);
    check("exit.c16.state", 32'(state), 1);
    check("exit.c16.timer", 32'(timer), 0);
    sensor = 4'b0001;
    step();
    sensor = 4'h0;
    check("exit.c17.state", 32'(state), 2);
    check("exit.c17.armed", 32'(armed), 1);

    // Disabled zone trip is ignored
    zone_en = 4'b1110; sensor = 4'b0001;
    step(3);
    check("masked.state", 32'(state), 2);
    zone_en = 4'hF;

    // Trigger zone 2, run entry delay and siren
    sensor = 4'b0100;
    step();
    check("entry.state", 32'(state), 3);
    check("entry.zone_id", 32'(zone_id), 2);
    check("entry.zone_valid", 32'(zone_valid), 1);
    check("entry.timer", 32'(timer), 7);
    sensor = 4'b1000;
    step();
    sensor = 4'h0;
    check("entry.hold_zone", 32'(zone_id), 2);
    step(6);
    check("entry.last.state", 32'(state), 3);
    check("entry.last.timer", 32'(timer), 0);
    check("entry.last.alarm", 32'(alarm), 0);
    step();
    check("alarm.first.state", 32'(state), 4);
    check("alarm.first.alarm", 32'(alarm), 1);
    check("alarm.first.timer", 32'(timer), 31);
    step(31);
    check("alarm.last.state", 32'(state), 4);
    check("alarm.last.alarm", 32'(alarm), 1);
    check("alarm.last.timer", 32'(timer), 0);
    step();
    check("alarm.done.state", 32'(state), 2);
    check("alarm.done.alarm", 32'(alarm), 0);
    check("alarm.done.zone_id", 32'(zone_id), 2);
    check("alarm.done.zone_valid", 32'(zone_valid), 1);

    // arm_req ignored while ARMED
    arm_req = 1'b1;
    step(2);
    arm_req = 1'b0;
    check("armreq_in_armed.state", 32'(state), 2);

    // Disarm, then simultaneous arm_req + disarm keeps DISARMED
    disarm = 1'b1;
    step();
    check("disarm.state", 32'(state), 0);
    check("disarm.zone_valid", 32'(zone_valid), 0);
    arm_req = 1'b1;
    step();
    check("arm_and_disarm.state", 32'(state), 0);
    arm_req = 1'b0; disarm = 1'b0;

    // Round-robin: reset ptr, two grants on 1010 separated by disarm/re-arm
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    arm_fully();
    check("rr.armed1.state", 32'(state), 2);
    sensor = 4'b1010;
    step();
    sensor = 4'h0;
    check("rr.grant1.zone_id", 32'(zone_id), 1);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    arm_fully();
    check("rr.armed2.state", 32'(state), 2);
    sensor = 4'b1010;
    step();
    sensor = 4'h0;
    check("rr.grant2.zone_id", 32'(zone_id), 3);
    check("rr.grant2.state", 32'(state), 3);

    // Disarm mid-ALARM
    step(8);
    check("midalarm.state", 32'(state), 4);
    step(5);
    disarm = 1'b1;
    step();
    disarm = 1'b0;
    check("midalarm_disarm.state", 32'(state), 0);
    check("midalarm_disarm.alarm", 32'(alarm), 0);
    check("midalarm_disarm.timer", 32'(timer), 0);
    check("midalarm_disarm.zone_valid", 32'(zone_valid), 0);

    // Reset mid-ALARM with arm_req and disarm also asserted
    arm_fully();
    sensor = 4'b0110;
    step();
    sensor = 4'h0;
    check("rerun.zone_id", 32'(zone_id), 1);
    step(13);
    check("rerun.alarm", 32'(alarm), 1);
    rst_n = 1'b0; arm_req = 1'b1; disarm = 1'b1;
    step();
    check_reset_vals("midalarm_reset");
    rst_n = 1'b1; arm_req = 1'b0; disarm = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
